mbist_mem_responder: RTL and testbench

Memory-side responder for the March-Y MBIST controller: a 2^CAWIDTH x 8-bit register-file memory that executes the controller's write/read commands and returns read data through a fixed two-edge read pipeline. It includes a single programmable fault-injection site (stuck-at-0, stuck-at-1, or up-transition fault), so the BIST flow can be shown to both pass on clean memory and flag injected defects. It also keeps saturating access counters and a sticky command-error flag for debug. It sits directly under the MBIST controller, in place of the plain memory model.

---
 rtl/mbist_mem_responder.sv | 114 +++++++++++
 tb/tb_mbist_mem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mbist_mem_responder.sv
// Memory-side responder for the March-Y MBIST controller: register-file array,
// two-edge read pipeline, one programmable fault site, and debug counters.
module mbist_mem_responder #(
  parameter int CAWIDTH = 4,
  parameter int DWIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CAWIDTH-1:0]        CA,
  input  logic                      we,
  input  logic                      re,
  input  logic [DWIDTH-1:0]         datain,
  output logic [DWIDTH-1:0]         dataout,
  output logic                      rvalid,
  input  logic                      fault_en,
  input  logic [1:0]                fault_type,
  input  logic [CAWIDTH-1:0]        fault_addr,
  input  logic [$clog2(DWIDTH)-1:0] fault_bit,
  output logic [7:0]                wr_count,
  output logic [7:0]                rd_count,
  output logic                      cmd_err
);

  localparam int         DEPTH  = 1 << CAWIDTH;
  localparam logic [1:0] FT_SA0 = 2'b01;
  localparam logic [1:0] FT_SA1 = 2'b10;
  localparam logic [1:0] FT_UTF = 2'b11;

  logic [DWIDTH-1:0]  r_mem [DEPTH];
  logic [CAWIDTH-1:0] r_raddr_p1;
  logic               r_vld_p1;
  logic [DWIDTH-1:0]  r_dout_p2;
  logic               r_vld_p2;
  logic [7:0]         r_wr_cnt;
  logic [7:0]         r_rd_cnt;
  logic               r_cmd_err;

  logic               w_rd_accept;
  logic [DWIDTH-1:0]  w_mask;
  logic [DWIDTH-1:0]  w_wdata;
  logic [DWIDTH-1:0]  w_rdata;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Stuck-at faults only mask the returned word; the array keeps the real data.
  function automatic logic [DWIDTH-1:0] rfault(input logic [DWIDTH-1:0] word,
                                               input logic              hit,
                                               input logic [1:0]        ftype,
                                               input logic [DWIDTH-1:0] mask);
    logic [DWIDTH-1:0] res;
    res = word;
    if (hit && ftype == FT_SA0) res = word & ~mask;
    if (hit && ftype == FT_SA1) res = word | mask;
    return res;
  endfunction

  // Up-transition fault: a stored 0 cannot be written to 1; 1->0 is unaffected.
  function automatic logic [DWIDTH-1:0] wfault(input logic [DWIDTH-1:0] din,
                                               input logic [DWIDTH-1:0] stored,
                                               input logic              hit,
                                               input logic [DWIDTH-1:0] mask);
    return hit ? (din & (stored | ~mask)) : din;
  endfunction

  always_comb begin
    w_mask = '0;
    if (int'(fault_bit) < DWIDTH) w_mask = DWIDTH'(1) << fault_bit;
  end

  assign w_rd_accept = re & ~we;
  assign w_wdata = wfault(datain, r_mem[CA],
                          fault_en && fault_type == FT_UTF && CA == fault_addr, w_mask);
  assign w_rdata = rfault(r_mem[r_raddr_p1], fault_en && r_raddr_p1 == fault_addr,
                          fault_type, w_mask);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[CA] <= w_wdata;
    end
  end

  // p1: sampling edge captures the read address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_raddr_p1 <= '0;
      r_vld_p1   <= 1'b0;
      r_dout_p2  <= '0;
      r_vld_p2   <= 1'b0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_cmd_err  <= 1'b0;
    end else begin
      if (w_rd_accept) r_raddr_p1 <= CA;
      r_vld_p1 <= w_rd_accept;
      // p2: array word (pre-write value on a same-edge write) reaches dataout
      if (r_vld_p1) r_dout_p2 <= w_rdata;
      r_vld_p2 <= r_vld_p1;
      if (we)          r_wr_cnt  <= sat_inc(r_wr_cnt);
      if (w_rd_accept) r_rd_cnt  <= sat_inc(r_rd_cnt);
      if (we && re)    r_cmd_err <= 1'b1;
    end
  end

  assign dataout  = r_dout_p2;
  assign rvalid   = r_vld_p2;
  assign wr_count = r_wr_cnt;
  assign rd_count = r_rd_cnt;
  assign cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_mbist_mem_responder.sv
// Directed bench for mbist_mem_responder: an array/queue model checked every
// cycle, plus literal expectations for the March-Y, fault and corner cases.
module tb_mbist_mem_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] CA = '0;
  logic       we = 1'b0;
  logic       re = 1'b0;
  logic [7:0] datain = '0;
  logic [7:0] dataout;
  logic       rvalid;
  logic       fault_en = 1'b0;
  logic [1:0] fault_type = 2'b00;
  logic [3:0] fault_addr = '0;
  logic [2:0] fault_bit = '0;
  logic [7:0] wr_count;
  logic [7:0] rd_count;
  logic       cmd_err;

  int total = 0;
  int bad = 0;

  mbist_mem_responder #(.CAWIDTH(4), .DWIDTH(8)) dut (
    .clk(clk), .rst(rst), .CA(CA), .we(we), .re(re), .datain(datain),
    .dataout(dataout), .rvalid(rvalid), .fault_en(fault_en),
    .fault_type(fault_type), .fault_addr(fault_addr), .fault_bit(fault_bit),
    .wr_count(wr_count), .rd_count(rd_count), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: array contents, one pending read, counters, sticky error.
  logic [7:0] m_mem [16];
  bit         m_pend;
  logic [3:0] m_paddr;
  bit         m_vld;
  logic [7:0] m_dout;
  int         m_wr, m_rd;
  bit         m_err;

  always @(posedge clk or negedge rst) begin
    logic [7:0] d;
    if (!rst) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_pend = 0; m_paddr = 0; m_vld = 0; m_dout = 0;
      m_wr = 0; m_rd = 0; m_err = 0;
    end else begin
      m_vld = m_pend;
      if (m_pend) begin
        d = m_mem[m_paddr];
        if (fault_en && m_paddr == fault_addr && fault_type == 2'b01) d[fault_bit] = 1'b0;
        if (fault_en && m_paddr == fault_addr && fault_type == 2'b10) d[fault_bit] = 1'b1;
        m_dout = d;
      end
      m_pend = 0;
      if (we) begin
        d = datain;
        if (fault_en && CA == fault_addr && fault_type == 2'b11 && m_mem[CA][fault_bit] == 1'b0)
          d[fault_bit] = 1'b0;
        m_mem[CA] = d;
        if (m_wr < 255) m_wr++;
        if (re) m_err = 1;
      end else if (re) begin
        m_pend = 1;
        m_paddr = CA;
        if (m_rd < 255) m_rd++;
      end
    end
  end

  always @(negedge clk) begin
    chk("mdl_rvalid", rvalid, m_vld);
    chk("mdl_dataout", dataout, m_dout);
    chk("mdl_wr_count", wr_count, m_wr);
    chk("mdl_rd_count", rd_count, m_rd);
    chk("mdl_cmd_err", cmd_err, m_err);
  end

  task automatic cyc(input logic w, input logic r, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    we = w; re = r; CA = a; datain = d;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 4'd0, 8'h00);
  endtask

  // Issue a read, then check the data two edges later.
  task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
    cyc(1'b0, 1'b1, a, 8'h00);
    idle();
    @(negedge clk);
    #1;
    chk({name, "_rvalid"}, rvalid, 1);
    chk(name, dataout, exp);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_dataout", dataout, 8'h00);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_cmd_err", cmd_err, 0);
    rst = 1'b1;

    // Traffic then reset: everything returns to zero
    cyc(1'b1, 1'b0, 4'd3, 8'h5A);
    cyc(1'b1, 1'b1, 4'd6, 8'h77);
    cyc(1'b0, 1'b1, 4'd3, 8'h00);
    idle();
    @(negedge clk); #2; rst = 1'b0;
    @(negedge clk); #1;
    chk("rst2_dataout", dataout, 8'h00);
    chk("rst2_rd_count", rd_count, 0);
    chk("rst2_cmd_err", cmd_err, 0);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) rd_chk("rst_mem", 4'(i), 8'h00);
    rst = 1'b0; #3; rst = 1'b1;

    // Clean March-Y sweep
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 4'(i), 8'h00);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 4'(i), 8'h00);
      cyc(1'b1, 1'b0, 4'(i), 8'hFF);
      cyc(1'b0, 1'b1, 4'(i), 8'h00);
    end
    for (int i = 15; i >= 0; i--) begin
      cyc(1'b0, 1'b1, 4'(i), 8'h00);
      cyc(1'b1, 1'b0, 4'(i), 8'h00);
      cyc(1'b0, 1'b1, 4'(i), 8'h00);
    end
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 4'(i), 8'h00);
    idle();
    @(negedge clk); #1;
    chk("march_wr_count", wr_count, 48);
    chk("march_rd_count", rd_count, 80);

    // Stuck-at-1 on addr 5 bit 3
    @(negedge clk);
    fault_en = 1'b1; fault_type = 2'b10; fault_addr = 4'd5; fault_bit = 3'd3;
    cyc(1'b1, 1'b0, 4'd5, 8'h00);
    rd_chk("sa1_addr5", 4'd5, 8'h08);
    rd_chk("sa1_addr4", 4'd4, 8'h00);

    // Up-transition fault on addr 9 bit 0
    @(negedge clk);
    fault_type = 2'b11; fault_addr = 4'd9; fault_bit = 3'd0;
    cyc(1'b1, 1'b0, 4'd9, 8'h00);
    cyc(1'b1, 1'b0, 4'd9, 8'hFF);
    rd_chk("utf_up", 4'd9, 8'hFE);
    cyc(1'b1, 1'b0, 4'd9, 8'h00);
    rd_chk("utf_down", 4'd9, 8'h00);

    // Conflict and read-after-write
    @(negedge clk);
    fault_en = 1'b0; fault_type = 2'b00;
    cyc(1'b1, 1'b1, 4'd2, 8'hA5);
    idle();
    @(negedge clk); #1;
    chk("conflict_rvalid", rvalid, 0);
    chk("conflict_cmd_err", cmd_err, 1);
    rd_chk("conflict_data", 4'd2, 8'hA5);
    chk("cmd_err_sticky", cmd_err, 1);
    cyc(1'b1, 1'b0, 4'd7, 8'h3C);
    rd_chk("raw_addr7", 4'd7, 8'h3C);

    // Saturation of the read counter
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, 4'(i), 8'h00);
    idle();
    @(negedge clk); #1;
    chk("rd_count_sat", rd_count, 255);

    // Reset between stage 1 and stage 2 drops the in-flight read
    cyc(1'b0, 1'b1, 4'd7, 8'h00);
    @(posedge clk); #2;
    rst = 1'b0; re = 1'b0;
    @(negedge clk); #1;
    chk("midrst_rvalid_in_rst", rvalid, 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("midrst_rvalid_after", rvalid, 0);
    end
    chk("midrst_dataout", dataout, 8'h00);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
